ldr_str_unit: RTL and testbench
===============================

# ldr_str_unit

Multi-cycle load/store unit for LDR/STR/LDRB/STRB. It sits between the core's decode/execute logic and the synchronous-read data memory, which has a 1-cycle read latency. It accepts one decoded load/store instruction with its register operands and computes the effective address. It drives the data memory port, aligns and formats load data, and returns register-file writebacks for Rd and for base-register (Rn) update.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: data memory word-address width (512 words).

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction and operands valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in_inst`  in  32  instruction. Fields: I=[25], P=[24], U=[23], B=[22], W=[21], L=[20], Rn=[19:16], Rd=[15:12], imm12=[11:0].
- `in_rn_val`  in  32  base register value.
- `in_rm_val`  in  32  offset register value, used when I=1; unshifted.
- `in_rd_val`  in  32  store data.
- `mem_addr`  out  ADDR_WIDTH  data memory word address.
- `mem_we`  out  1  write strobe.
- `mem_be`  out  4  byte enables for the write.
- `mem_wd`  out  32  write data.
- `mem_rd`  in  32  read data, valid 1 cycle after the address is presented.
- `wb_valid`  out  1  1-cycle completion pulse.
- `wb_rd_we`  out  1  write `wb_rd_data` to `wb_rd`.
- `wb_rd`  out  4  load destination register.
- `wb_rd_data`  out  32  formatted load data.
- `wb_rn_we`  out  1  write `wb_rn_data` to `wb_rn`.
- `wb_rn`  out  4  base register.
- `wb_rn_data`  out  32  updated base value.
- `busy`  out  1  equals `!in_ready`; the core stalls on it.

## Operation
- Acceptance: an instruction is accepted when `in_valid && in_ready` is high at a rising edge. All inputs are captured at that edge. The condition code is already resolved upstream; every accepted instruction executes.
- Offset: `off` = `in_rm_val` when I=1, else zero-extended imm12.
- Offset address: `calc` = U ? rn+off : rn−off. Arithmetic is 32-bit, modulo 2^32; no overflow detection.
- Effective address: `ea` = P ? calc : rn.
- Memory address: `mem_addr` = `ea[ADDR_WIDTH+1:2]`. Upper bits are dropped, so addresses wrap modulo memory size.
- Base writeback: when (!P || W), `wb_rn_we`=1 and `wb_rn_data`=calc.
- Base writeback suppressed: for a load with Rd==Rn, `wb_rn_we` is forced to 0 and the loaded value wins.
- Word store: `mem_be`=4'hF and `mem_wd`=rd_val; `ea[1:0]` is ignored.
- Word load: data is `mem_rd` rotated right by 8·`ea[1:0]`.
- Rd==15 on a load is reported as-is; pc redirect is the core's responsibility.
- FSM states: IDLE, ISSUE, RDWAIT, DONE.
  - IDLE → ISSUE on accept.
  - ISSUE → RDWAIT for a load.
  - ISSUE → DONE for a store.
  - RDWAIT → DONE.
  - DONE → IDLE.
- Output defaults: all `mem_*` and `wb_*` outputs are 0 except in the states listed under Timing.

## Timing
- Cycle 0 is the cycle in which acceptance occurs.
- Store sequence:
  - Cycle 1 (ISSUE): `mem_addr`, `mem_wd` and `mem_be` valid; `mem_we`=1 for exactly this cycle.
  - Cycle 2 (DONE): `wb_valid`=1, `wb_rd_we`=0, and `wb_rn_*` as applicable.
  - Cycle 3: `in_ready`=1.
- Load sequence:
  - Cycle 1 (ISSUE): `mem_addr` valid, `mem_we`=0.
  - Cycle 2 (RDWAIT): `mem_rd` sampled, formatted and registered.
  - Cycle 3 (DONE): `wb_valid`=1, `wb_rd_we`=1, and `wb_rn_*` as applicable.
  - Cycle 4: `in_ready`=1.
- Writeback has no backpressure: the `wb_*` outputs are valid only while `wb_valid`=1.
- Throughput: one store every 3 cycles; one load every 4 cycles.
- Reset asserted at any time:
  - FSM goes to IDLE immediately (asynchronously).
  - All outputs are 0, except `in_ready`, which is 1 and `busy`, which is 0.
  - A store in progress is abandoned; `mem_we` drops immediately.
  - No `wb_valid` is produced for the aborted instruction.
- While reset is high, `in_valid` is ignored.

## Configuration
- `LDST_BYTE_EN` defined: B=1 selects byte access.
  - Byte store: `mem_wd`={4{rd_val[7:0]}} and `mem_be`=one-hot(`ea[1:0]`).
  - Byte load: data is zero-extended byte lane `ea[1:0]` of `mem_rd`.
- `LDST_BYTE_EN` undefined: the B bit is ignored and every access is a word access.

## Test plan
- Reset: assert `reset` mid-cycle → all `mem_*`/`wb_*` outputs 0 immediately; `in_ready`=1 after release.
- STR word, rn=0x10, imm=4, P=1, U=1, W=0, rd_val=0xDEADBEEF → in cycle 1: `mem_addr`=5, `mem_we`=1 for one cycle, `mem_be`=F, `mem_wd`=0xDEADBEEF. Cycle 2: `wb_valid`=1, `wb_rd_we`=0, `wb_rn_we`=0.
- LDR word, same address, memory returns 0xDEADBEEF → cycle 3: `wb_rd_data`=0xDEADBEEF, `wb_rd_we`=1; `in_ready` back at cycle 4.
- LDR, rn=0x15, imm=0, P=1 → `mem_addr`=5 and `wb_rd_data`=0xEFDEADBE (rotated right 8).
- LDRB post-index, rn=0x14, imm=1, P=0, U=0, word at 5 = 0xDEADBEEF, Rd≠Rn, `LDST_BYTE_EN` defined → `wb_rd_data`=0x000000EF, `wb_rn_we`=1, `wb_rn_data`=0x13.
- LDR with W=1 and Rd==Rn → `wb_rn_we`=0. Separately, reset during RDWAIT → no `wb_valid`, FSM in IDLE.

Source files
------------

// File: rtl/ldr_str_unit.sv
`default_nettype none
// ============================================================================
// Module      : ldr_str_unit
// Description : Multi-cycle LDR/STR/LDRB/STRB unit. It computes the
//               effective address, drives a 1-cycle-latency synchronous data
//               memory, formats load data and returns Rd/Rn writebacks.
//               Optional feature macro: LDST_BYTE_EN (B bit selects byte
//               access; when undefined every access is a word access).
// Revision    : 1.0 - initial release
// ============================================================================
module ldr_str_unit #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [31:0]           in_rn_val,
    input  logic [31:0]           in_rm_val,
    input  logic [31:0]           in_rd_val,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd,
    output logic                  wb_valid,
    output logic                  wb_rd_we,
    output logic [3:0]            wb_rd,
    output logic [31:0]           wb_rd_data,
    output logic                  wb_rn_we,
    output logic [3:0]            wb_rn,
    output logic [31:0]           wb_rn_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Instruction fields and address arithmetic on the incoming operands
    logic                  w_accept;
    logic                  w_load;
    logic                  w_byte;
    logic [31:0]           w_off;
    logic [31:0]           w_calc;
    logic [31:0]           w_ea;
    logic                  w_rn_we;
    logic [3:0]            w_be;
    logic [31:0]           w_wd;
    logic [31:0]           w_fmt;
    logic                  w_unused;

    // State captured at acceptance
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_lane;
    logic [31:0]           r_calc;
    logic [31:0]           r_wd;
    logic [3:0]            r_be;
    logic [3:0]            r_rd;
    logic [3:0]            r_rn;
    logic                  r_load;
    logic                  r_byte;
    logic                  r_rn_we;
    logic [31:0]           r_ld_data;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_load   = in_inst[20];
    assign w_off    = in_inst[25] ? in_rm_val : {20'd0, in_inst[11:0]};
    assign w_calc   = in_inst[23] ? (in_rn_val + w_off) : (in_rn_val - w_off);
    assign w_ea     = in_inst[24] ? w_calc : in_rn_val;
    // A load into its own base register keeps the loaded value, not the update
    assign w_rn_we  = (!in_inst[24] || in_inst[21]) &&
                      !(w_load && (in_inst[15:12] == in_inst[19:16]));

`ifdef LDST_BYTE_EN
    assign w_byte = in_inst[22];
`else
    assign w_byte = 1'b0;
`endif

    // Condition field and the address bits above the memory size are dropped
    assign w_unused = ^{in_inst[31:26], in_inst[22], w_ea[31:ADDR_WIDTH+2]};

    // Store data/byte-enable: word stores ignore the low address bits
    always_comb begin
        w_be = 4'hF;
        w_wd = in_rd_val;
        if (w_byte) begin
            w_be = 4'b0001 << w_ea[1:0];
            w_wd = {4{in_rd_val[7:0]}};
        end
    end

    // Load formatting: word loads rotate right by the byte offset, byte loads
    // zero-extend the addressed lane
    always_comb begin
        w_fmt = mem_rd;
        if (r_byte) begin
            case (r_lane)
                2'd0:    w_fmt = {24'd0, mem_rd[7:0]};
                2'd1:    w_fmt = {24'd0, mem_rd[15:8]};
                2'd2:    w_fmt = {24'd0, mem_rd[23:16]};
                default: w_fmt = {24'd0, mem_rd[31:24]};
            endcase
        end else begin
            case (r_lane)
                2'd0:    w_fmt = mem_rd;
                2'd1:    w_fmt = {mem_rd[7:0],  mem_rd[31:8]};
                2'd2:    w_fmt = {mem_rd[15:0], mem_rd[31:16]};
                default: w_fmt = {mem_rd[23:0], mem_rd[31:24]};
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture at acceptance and load-data register in RDWAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_lane    <= 2'd0;
            r_calc    <= 32'd0;
            r_wd      <= 32'd0;
            r_be      <= 4'd0;
            r_rd      <= 4'd0;
            r_rn      <= 4'd0;
            r_load    <= 1'b0;
            r_byte    <= 1'b0;
            r_rn_we   <= 1'b0;
            r_ld_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= w_ea[ADDR_WIDTH+1:2];
                r_lane  <= w_ea[1:0];
                r_calc  <= w_calc;
                r_wd    <= w_wd;
                r_be    <= w_be;
                r_rd    <= in_inst[15:12];
                r_rn    <= in_inst[19:16];
                r_load  <= w_load;
                r_byte  <= w_byte;
                r_rn_we <= w_rn_we;
            end
            if (r_state == S_RDWAIT) begin
                r_ld_data <= w_fmt;
            end
        end
    end

    // Next-state and output decode; outputs are zero outside ISSUE/DONE
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_be     = 4'd0;
        mem_wd     = 32'd0;
        wb_valid   = 1'b0;
        wb_rd_we   = 1'b0;
        wb_rd      = 4'd0;
        wb_rd_data = 32'd0;
        wb_rn_we   = 1'b0;
        wb_rn      = 4'd0;
        wb_rn_data = 32'd0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr = r_addr;
                if (r_load) begin
                    w_next = S_RDWAIT;
                end else begin
                    mem_we = 1'b1;
                    mem_be = r_be;
                    mem_wd = r_wd;
                    w_next = S_DONE;
                end
            end
            S_RDWAIT: begin
                w_next = S_DONE;
            end
            default: begin
                wb_valid   = 1'b1;
                wb_rd_we   = r_load;
                wb_rd      = r_rd;
                wb_rd_data = r_load ? r_ld_data : 32'd0;
                wb_rn_we   = r_rn_we;
                wb_rn      = r_rn;
                wb_rn_data = r_calc;
                w_next     = S_IDLE;
            end
        endcase
    end

    assign busy = !in_ready;

endmodule
`default_nettype wire

// File: tb/tb_ldr_str_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldr_str_unit
// Description : Directed self-checking bench for ldr_str_unit with a
//               1-cycle-latency synchronous memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldr_str_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rn_val;
    logic [31:0] in_rm_val;
    logic [31:0] in_rd_val;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        wb_valid;
    logic        wb_rd_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        wb_rn_we;
    logic [3:0]  wb_rn;
    logic [31:0] wb_rn_data;
    logic        busy;

    logic [31:0] mem [0:511];
    int          n_checks;
    int          n_pass;

    ldr_str_unit #(.ADDR_WIDTH(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_rn_val  (in_rn_val),
        .in_rm_val  (in_rm_val),
        .in_rd_val  (in_rd_val),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .wb_valid   (wb_valid),
        .wb_rd_we   (wb_rd_we),
        .wb_rd      (wb_rd),
        .wb_rd_data (wb_rd_data),
        .wb_rn_we   (wb_rn_we),
        .wb_rn      (wb_rn),
        .wb_rn_data (wb_rn_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: byte-enabled write, registered read
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wd[b*8 +: 8];
            end
        end
        mem_rd <= mem[mem_addr];
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for IDLE, presents one instruction and returns 1 ns
    // into cycle 1
    task automatic start(input logic [31:0] inst, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [31:0] rd);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_value("idle_wait", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_rn_val = rn;
        in_rm_val = rm;
        in_rd_val = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_rn_val = 32'd0;
        in_rm_val = 32'd0;
        in_rd_val = 32'd0;
        mem_rd    = 32'd0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;

        #3;
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_value("rst_busy",     {31'd0, busy},     32'd0);
        check_value("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check_value("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // STR word pre-index: rn=0x10 + 4 -> word 5
        start(32'h01812004, 32'h10, 32'd0, 32'hDEADBEEF);
        check_value("str_addr",  {23'd0, mem_addr}, 32'd5);
        check_value("str_we",    {31'd0, mem_we},   32'd1);
        check_value("str_be",    {28'd0, mem_be},   32'hF);
        check_value("str_wd",    mem_wd,            32'hDEADBEEF);
        check_value("str_busy",  {31'd0, busy},     32'd1);
        step();
        check_value("str_we_c2", {31'd0, mem_we},   32'd0);
        check_value("str_wbv",   {31'd0, wb_valid}, 32'd1);
        check_value("str_rdwe",  {31'd0, wb_rd_we}, 32'd0);
        check_value("str_rnwe",  {31'd0, wb_rn_we}, 32'd0);
        step();
        check_value("str_ready", {31'd0, in_ready}, 32'd1);

        // LDR word, same address
        start(32'h01912004, 32'h10, 32'd0, 32'd0);
        check_value("ldr_addr",  {23'd0, mem_addr}, 32'd5);
        check_value("ldr_we",    {31'd0, mem_we},   32'd0);
        step();
        check_value("ldr_wbv_c2", {31'd0, wb_valid}, 32'd0);
        step();
        check_value("ldr_wbv",   {31'd0, wb_valid}, 32'd1);
        check_value("ldr_rdwe",  {31'd0, wb_rd_we}, 32'd1);
        check_value("ldr_rd",    {28'd0, wb_rd},    32'd2);
        check_value("ldr_data",  wb_rd_data,        32'hDEADBEEF);
        check_value("ldr_rnwe",  {31'd0, wb_rn_we}, 32'd0);
        check_value("ldr_rdy_c3", {31'd0, in_ready}, 32'd0);
        step();
        check_value("ldr_ready", {31'd0, in_ready}, 32'd1);

        // LDR unaligned: rn=0x15 -> rotate right by 8
        start(32'h01912000, 32'h15, 32'd0, 32'd0);
        check_value("rot_addr",  {23'd0, mem_addr}, 32'd5);
        step(); step();
        check_value("rot_data",  wb_rd_data,        32'hEFDEADBE);

        // LDRB post-index, subtract: ea=0x14, new base 0x13
        start(32'h00512001, 32'h14, 32'd0, 32'd0);
        check_value("ldrb_addr", {23'd0, mem_addr}, 32'd5);
        step(); step();
`ifdef LDST_BYTE_EN
        check_value("ldrb_data", wb_rd_data,        32'h000000EF);
`else
        check_value("ldrb_data", wb_rd_data,        32'hDEADBEEF);
`endif
        check_value("ldrb_rnwe", {31'd0, wb_rn_we}, 32'd1);
        check_value("ldrb_rnd",  wb_rn_data,        32'h13);

        // LDR writeback with Rd==Rn: base update suppressed
        start(32'h01B33004, 32'h10, 32'd0, 32'd0);
        step(); step();
        check_value("rdrn_data", wb_rd_data,        32'hDEADBEEF);
        check_value("rdrn_rnwe", {31'd0, wb_rn_we}, 32'd0);

        // STR register offset, subtract, pre-index writeback: 0x100-0x10
        start(32'h03245000, 32'h100, 32'h10, 32'h12345678);
        check_value("rof_addr",  {23'd0, mem_addr}, 32'h3C);
        check_value("rof_wd",    mem_wd,            32'h12345678);
        step();
        check_value("rof_rnwe",  {31'd0, wb_rn_we}, 32'd1);
        check_value("rof_rn",    {28'd0, wb_rn},    32'd4);
        check_value("rof_rnd",   wb_rn_data,        32'hF0);

        // Address wrap: ea=0x804 maps to word 1
        start(32'h01812000, 32'h804, 32'd0, 32'h0BADF00D);
        check_value("wrap_addr", {23'd0, mem_addr}, 32'd1);
        step();
        start(32'h01912000, 32'h4, 32'd0, 32'd0);
        step(); step();
        check_value("wrap_data", wb_rd_data,        32'h0BADF00D);

        // Base below zero wraps modulo 2^32: 0 - 4
        start(32'h01367004, 32'h0, 32'd0, 32'd0);
        check_value("neg_addr",  {23'd0, mem_addr}, 32'h1FF);
        step(); step();
        check_value("neg_rnwe",  {31'd0, wb_rn_we}, 32'd1);
        check_value("neg_rnd",   wb_rn_data,        32'hFFFFFFFC);

        // STRB at ea=0x22
        start(32'h01C12000, 32'h22, 32'd0, 32'h000000AB);
        check_value("strb_addr", {23'd0, mem_addr}, 32'd8);
`ifdef LDST_BYTE_EN
        check_value("strb_be",   {28'd0, mem_be},   32'h4);
        check_value("strb_wd",   mem_wd,            32'hABABABAB);
`else
        check_value("strb_be",   {28'd0, mem_be},   32'hF);
        check_value("strb_wd",   mem_wd,            32'h000000AB);
`endif
        step();

        // Reset during RDWAIT: no writeback, back to IDLE
        start(32'h01912004, 32'h10, 32'd0, 32'd0);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_value("rrd_ready", {31'd0, in_ready}, 32'd1);
        check_value("rrd_busy",  {31'd0, busy},     32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_value("rrd_wbv", {31'd0, wb_valid}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        check_value("rrd_wbv_after", {31'd0, wb_valid}, 32'd0);

        // Reset during store ISSUE: write strobe drops at once, store abandoned
        start(32'h01812000, 32'h40, 32'd0, 32'hCAFEF00D);
        check_value("rst_st_we1", {31'd0, mem_we},  32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_value("rst_st_we0", {31'd0, mem_we},  32'd0);
        check_value("rst_st_addr", {23'd0, mem_addr}, 32'd0);
        check_value("rst_st_wd",  mem_wd,           32'd0);
        @(negedge clk);
        reset = 1'b0;
        start(32'h01912000, 32'h40, 32'd0, 32'd0);
        step(); step();
        check_value("rst_st_mem", wb_rd_data,       32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
